hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall sequencer for the 5-stage RV32I core. Drives the hold (stall) and synchronous-clear (flush) controls of the F/D, D/E, E/M and M/W pipeline registers, handling load-use hazards, taken-branch redirects and data-memory wait states. Includes a memory-wait watchdog that parks the pipeline in a fault state, plus free-running performance counters. Sits alongside the pipeline registers; all stall/flush outputs feed their enable/clear inputs.

## Interface
- `REG_AW`, 5: register-address width.
- `WAIT_TIMEOUT`, 255: consecutive memory-wait cycles before a fault (range 1..65535).
- `clk`  in  1: core clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rs1_d`, `rs2_d`  in  REG_AW: source registers of the instruction in Decode.
- `rd_e`  in  REG_AW: destination register of the instruction in Execute.
- `mem_read_e`  in  1: instruction in Execute is a load.
- `branch_taken_e`  in  1: Execute resolved a taken branch or jump.
- `mem_req_m`  in  1: Memory stage issues a data-memory access.
- `dmem_ready`  in  1: data memory completes the access this cycle.
- `stall_f`, `stall_d`, `stall_e`, `stall_m`  out  1: hold PC, F/D, D/E and E/M registers respectively.
- `flush_d`, `flush_e`  out  1: clear F/D and D/E registers to 0 (NOP) at the next edge.
- `state`  out  2: 0 RUN, 1 MEM_WAIT, 2 FAULT.
- `timeout_err`  out  1: sticky watchdog fault flag.
- `stall_cycles`  out  32: count of cycles with `stall_f`=1, wrapping.
- `flush_events`  out  32: count of cycles with `flush_d`=1, wrapping.

## Operation
- Derived terms:
  - `mem_stall = mem_req_m & ~dmem_ready`
  - `load_use = mem_read_e & (rd_e != 0) & (rd_e == rs1_d | rd_e == rs2_d)`
- **RUN and MEM_WAIT** use the same output priority (highest first):
  1. `mem_stall`: all four stall outputs 1; both flushes 0.
  2. `branch_taken_e`: `flush_d` = 1, `flush_e` = 1; stalls 0. This takes priority over `load_use`, because the dependent instruction is squashed.
  3. `load_use`: `stall_f` = 1, `stall_d` = 1, `flush_e` = 1; `stall_e`, `stall_m` and `flush_d` = 0.
  4. Otherwise all stall and flush outputs are 0.
- **Transitions:**
  - RUN → MEM_WAIT when `mem_stall`=1. `wait_cnt` loads 1.
  - MEM_WAIT → RUN on `dmem_ready`=1. Priorities 2–4 apply in that same cycle, and `wait_cnt` clears.
  - MEM_WAIT stays in MEM_WAIT while `mem_stall`=1. `wait_cnt` increments.
  - MEM_WAIT → FAULT when `mem_stall`=1 and `wait_cnt` == `WAIT_TIMEOUT`. `timeout_err` sets.
  - MEM_WAIT → RUN if `mem_req_m` drops without `dmem_ready`. No stall in that cycle.
  - FAULT is absorbing until reset. It drives all four stalls = 1 and `flush_d` = `flush_e` = 1, ignoring all inputs.
- **Branch during a memory stall:** the branch is held in Execute by `stall_e`. Its flush occurs in the first released cycle. No pending-branch storage is needed.
- **Counters:**
  - `stall_cycles` increments at each edge where `stall_f`=1, including FAULT.
  - `flush_events` increments where `flush_d`=1.
  - Both wrap from 0xFFFFFFFF to 0.
  - `wait_cnt` is 16 bits and internal.

## Timing
- All stall/flush outputs are combinational from the current inputs and registered `state`, with zero-cycle latency. They are forced to 0 while `rst_n`=0.
- Reset values: `state` = RUN (0), `timeout_err` = 0, `stall_cycles` = 0, `flush_events` = 0, `wait_cnt` = 0.
- A load-use hazard costs exactly 1 bubble. The next cycle the load is in Memory, so `load_use` drops.
- A taken branch costs 2 bubbles: the F/D and D/E contents are cleared at one edge.
- A memory wait of N cycles holds the pipeline for exactly N cycles. `state` reads MEM_WAIT from the 2nd cycle onward.
- FAULT is entered on the edge after the (`WAIT_TIMEOUT`+1)-th consecutive `mem_stall` cycle.
- Reset asserted mid-MEM_WAIT or in FAULT returns to RUN immediately and asynchronously, with all outputs 0.

## Test plan
- **Load-use:** `mem_read_e`=1, `rd_e`=5, `rs2_d`=5, one cycle → `stall_f`=`stall_d`=`flush_e`=1 for 1 cycle; `stall_cycles`=1.
- **x0 and non-load:**
  - `rd_e`=0 with `rs1_d`=0 and `mem_read_e`=1 → no stall.
  - `mem_read_e`=0 with matching registers → no stall.
- **Branch beats load-use:** `branch_taken_e`=1 and `load_use` true together → `flush_d`=`flush_e`=1, `stall_f`=0; `flush_events`=1.
- **Memory wait 3 cycles with a branch in Execute:**
  - Cycles 0–2: all stalls 1; `state`=1 in cycles 1–2.
  - Cycle 3 (`dmem_ready`=1): flushes asserted, `state` returns to 0.
  - `stall_cycles`=3.
- **Watchdog with `WAIT_TIMEOUT`=4:** `mem_stall` held for 6 cycles → `state`=2 and `timeout_err`=1 after the 5th stall edge. All stalls and flushes stay 1 even after `dmem_ready`=1.
- **Reset mid-fault:** drop `rst_n` asynchronously in FAULT → outputs 0 immediately; after release, `state`=0 and counters read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline.
// Resolves load-use, taken-branch and data-memory wait hazards, parks the
// pipeline in FAULT when a memory wait exceeds WAIT_TIMEOUT cycles, and
// keeps free-running stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              mem_read_e,
  input  logic              branch_taken_e,
  input  logic              mem_req_m,
  input  logic              dmem_ready,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        state,
  output logic              timeout_err,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT = 16'(WAIT_TIMEOUT);

  state_t      cur_state;
  state_t      next_state;
  logic [15:0] wait_cnt;
  logic [15:0] next_wait_cnt;
  logic        next_timeout;
  logic        mem_stall;
  logic        load_use;

  assign mem_stall = mem_req_m & ~dmem_ready;
  assign load_use  = mem_read_e & (rd_e != '0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
  assign state     = cur_state;

  // State register, wait counter and sticky watchdog flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      cur_state   <= next_state;
      wait_cnt    <= next_wait_cnt;
      timeout_err <= next_timeout;
    end
  end

  // Next-state logic: memory-wait tracking and watchdog
  always_comb begin
    next_state    = cur_state;
    next_wait_cnt = wait_cnt;
    next_timeout  = timeout_err;
    unique case (cur_state)
      RUN: begin
        if (mem_stall) begin
          next_state    = MEM_WAIT;
          next_wait_cnt = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt == TIMEOUT) begin
            next_state   = FAULT;
            next_timeout = 1'b1;
          end else begin
            next_wait_cnt = wait_cnt + 16'd1;
          end
        end else begin
          // Either dmem_ready arrived or the request was withdrawn
          next_state    = RUN;
          next_wait_cnt = '0;
        end
      end
      FAULT: begin
        next_state = FAULT;
      end
      default: begin
        next_state    = RUN;
        next_wait_cnt = '0;
      end
    endcase
  end

  // Output logic: prioritised stall/flush controls, forced low during reset
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (rst_n) begin
      if (cur_state == FAULT) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end else if (branch_taken_e) begin
        // A pending load-use is moot: the dependent instruction is squashed
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // Performance counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_f) stall_cycles <= stall_cycles + 32'd1;
      if (flush_d) flush_events <= flush_events + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl (WAIT_TIMEOUT = 4).
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_d, rs2_d, rd_e;
  logic        mem_read_e, branch_taken_e, mem_req_m, dmem_ready;
  logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  logic [1:0]  state;
  logic        timeout_err;
  logic [31:0] stall_cycles, flush_events;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .WAIT_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
    .mem_read_e(mem_read_e), .branch_taken_e(branch_taken_e),
    .mem_req_m(mem_req_m), .dmem_ready(dmem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e),
    .state(state), .timeout_err(timeout_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       mrd, br, req, rdy;
    logic [5:0] ctl;   // {sf, sd, se, sm, fd, fe}
    logic [1:0] st;    // state seen while this vector is applied
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] ctl_now();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e};
  endfunction

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mrd, input logic br, input logic req, input logic rdy);
    rs1_d = rs1; rs2_d = rs2; rd_e = rd;
    mem_read_e = mrd; branch_taken_e = br; mem_req_m = req; dmem_ready = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock edge and return at the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
  endtask

  int exp_stall;
  int exp_flush;

  initial begin
    //                 rs1   rs2   rd   mrd br  req rdy  ctl        st
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 6'b000000, 2'd0}; // idle
    vecs[1]  = '{5'd1, 5'd5, 5'd5, 1, 0, 0, 0, 6'b110001, 2'd0}; // load-use rs2
    vecs[2]  = '{5'd7, 5'd2, 5'd7, 1, 0, 0, 0, 6'b110001, 2'd0}; // load-use rs1
    vecs[3]  = '{5'd0, 5'd3, 5'd0, 1, 0, 0, 0, 6'b000000, 2'd0}; // x0 target
    vecs[4]  = '{5'd5, 5'd5, 5'd5, 0, 0, 0, 0, 6'b000000, 2'd0}; // not a load
    vecs[5]  = '{5'd5, 5'd0, 5'd5, 1, 1, 0, 0, 6'b000011, 2'd0}; // branch beats load-use
    vecs[6]  = '{5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 6'b000011, 2'd0}; // branch only
    vecs[7]  = '{5'd5, 5'd0, 5'd5, 1, 1, 1, 0, 6'b111100, 2'd0}; // mem stall beats all
    vecs[8]  = '{5'd9, 5'd9, 5'd9, 1, 0, 0, 0, 6'b110001, 2'd1}; // req dropped in MEM_WAIT
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 0, 1, 1, 1, 6'b000011, 2'd0}; // ready: no stall
    vecs[10] = '{5'd4, 5'd6, 5'd3, 1, 0, 0, 0, 6'b000000, 2'd0}; // no register match

    // Reset state
    rst_n = 1'b0;
    idle();
    #2;
    chk("rst_ctl", 32'(ctl_now()), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_stall_cnt", stall_cycles, 32'd0);
    chk("rst_flush_cnt", flush_events, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single-cycle vectors with a reference counter model
    exp_stall = 0;
    exp_flush = 0;
    for (int unsigned i = 0; i < 11; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mrd, vecs[i].br,
            vecs[i].req, vecs[i].rdy);
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      exp_stall += int'(vecs[i].ctl[5]);
      exp_flush += int'(vecs[i].ctl[1]);
      step();
    end
    idle();
    #1;
    chk("tbl_stall_cnt", stall_cycles, 32'(exp_stall));
    chk("tbl_flush_cnt", flush_events, 32'(exp_flush));
    chk("tbl_state", 32'(state), 32'd0);

    // Load-use costs exactly one bubble
    do_reset();
    drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    #1;
    chk("lu_after_ctl", 32'(ctl_now()), 32'd0);
    chk("lu_stall_cnt", stall_cycles, 32'd1);

    // Branch beats load-use: one flush event
    do_reset();
    drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("blu_ctl", 32'(ctl_now()), 32'b000011);
    step();
    idle();
    #1;
    chk("blu_flush_cnt", flush_events, 32'd1);
    chk("blu_stall_cnt", stall_cycles, 32'd0);

    // 3-cycle memory wait with a branch held in Execute
    do_reset();
    for (int unsigned c = 0; c < 3; c++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      chk($sformatf("mw%0d_ctl", c), 32'(ctl_now()), 32'b111100);
      chk($sformatf("mw%0d_state", c), 32'(state), (c == 0) ? 32'd0 : 32'd1);
      step();
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("mw3_ctl", 32'(ctl_now()), 32'b000011);
    chk("mw3_state", 32'(state), 32'd1);
    step();
    idle();
    #1;
    chk("mw_end_state", 32'(state), 32'd0);
    chk("mw_stall_cnt", stall_cycles, 32'd3);
    chk("mw_flush_cnt", flush_events, 32'd1);

    // Watchdog: WAIT_TIMEOUT = 4, FAULT after the 5th stall edge
    do_reset();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int unsigned c = 0; c < 4; c++) step();
    #1;
    chk("wd4_state", 32'(state), 32'd1);
    chk("wd4_terr", 32'(timeout_err), 32'd0);
    step();
    #1;
    chk("wd5_state", 32'(state), 32'd2);
    chk("wd5_terr", 32'(timeout_err), 32'd1);
    chk("wd5_ctl", 32'(ctl_now()), 32'b111111);
    chk("wd5_stall_cnt", stall_cycles, 32'd5);
    chk("wd5_flush_cnt", flush_events, 32'd0);
    step();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("wd_rdy_ctl", 32'(ctl_now()), 32'b111111);
    chk("wd_rdy_state", 32'(state), 32'd2);
    chk("wd6_stall_cnt", stall_cycles, 32'd6);
    chk("wd6_flush_cnt", flush_events, 32'd1);
    step();
    #1;
    chk("wd_hold_state", 32'(state), 32'd2);

    // Asynchronous reset while in FAULT
    #1;
    rst_n = 1'b0;
    #1;
    chk("rf_ctl", 32'(ctl_now()), 32'd0);
    chk("rf_state", 32'(state), 32'd0);
    chk("rf_terr", 32'(timeout_err), 32'd0);
    chk("rf_stall_cnt", stall_cycles, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step();
    #1;
    chk("rf_post_state", 32'(state), 32'd0);
    chk("rf_post_ctl", 32'(ctl_now()), 32'd0);
    chk("rf_post_flush_cnt", flush_events, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
